somador_serie: RTL

//  Bit-serial adder/subtractor for the simple calculator datapath. Sits directly downstream
//  of the sign/magnitude-to-two's-complement stage and consumes its 9-bit operands.

---
 rtl/somador_serie.sv | 110 +++++++++++
 1 files changed

// File: rtl/somador_serie.sv
// Bit-serial two's-complement adder/subtractor: one bit per clock, LSB first,
// with a signed-overflow flag and a one-cycle completion pulse.
module somador_serie #(
   parameter int LARGURA = 9
) (
   input  logic               relogio,
   input  logic               reinicio_n,
   input  logic [LARGURA-1:0] operando_a,
   input  logic [LARGURA-1:0] operando_b,
   input  logic               operacao,
   input  logic               inicio,
   output logic               ocupado,
   output logic               pronto,
   output logic [LARGURA-1:0] resultado,
   output logic               transbordo,
   output logic [1:0]         estado_dbg
);

   localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      CALCULA = 2'd1,
      FIM     = 2'd2
   } estado_t;

   estado_t              estado_q;
   logic [LARGURA-1:0]   reg_a_q;
   logic [LARGURA-1:0]   reg_b_q;
   logic [LARGURA-1:0]   parcial_q;
   logic [CW-1:0]        contador_q;
   logic                 carry_q;
   logic                 ocupado_q;
   logic                 pronto_q;
   logic [LARGURA-1:0]   resultado_q;
   logic                 transbordo_q;

   logic                 soma_bit;
   logic                 carry_d;
   logic [LARGURA-1:0]   parcial_d;

   // Full-adder slice on the current LSBs; the sum bit enters the partial sum from the top.
   always_comb begin
      soma_bit  = reg_a_q[0] ^ reg_b_q[0] ^ carry_q;
      carry_d   = (reg_a_q[0] & reg_b_q[0]) | (reg_a_q[0] & carry_q) | (reg_b_q[0] & carry_q);
      parcial_d = {soma_bit, parcial_q[LARGURA-1:1]};
   end

   always_ff @(posedge relogio or negedge reinicio_n) begin
      if (!reinicio_n) begin
         estado_q     <= ESPERA;
         reg_a_q      <= '0;
         reg_b_q      <= '0;
         parcial_q    <= '0;
         contador_q   <= '0;
         carry_q      <= 1'b0;
         ocupado_q    <= 1'b0;
         pronto_q     <= 1'b0;
         resultado_q  <= '0;
         transbordo_q <= 1'b0;
      end else begin
         case (estado_q)
            ESPERA: begin
               pronto_q <= 1'b0;
               if (inicio) begin
                  // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
                  reg_a_q    <= operando_a;
                  reg_b_q    <= operacao ? ~operando_b : operando_b;
                  carry_q    <= operacao;
                  contador_q <= '0;
                  parcial_q  <= '0;
                  ocupado_q  <= 1'b1;
                  estado_q   <= CALCULA;
               end
            end
            CALCULA: begin
               reg_a_q    <= {1'b0, reg_a_q[LARGURA-1:1]};
               reg_b_q    <= {1'b0, reg_b_q[LARGURA-1:1]};
               carry_q    <= carry_d;
               parcial_q  <= parcial_d;
               contador_q <= contador_q + CW'(1);
               if (contador_q == CW'(LARGURA - 1)) begin
                  // carry_q is the carry into the MSB, carry_d the carry out of it.
                  resultado_q  <= parcial_d;
                  transbordo_q <= carry_q ^ carry_d;
                  pronto_q     <= 1'b1;
                  estado_q     <= FIM;
               end
            end
            FIM: begin
               pronto_q  <= 1'b0;
               ocupado_q <= 1'b0;
               estado_q  <= ESPERA;
            end
            default: begin
               pronto_q  <= 1'b0;
               ocupado_q <= 1'b0;
               estado_q  <= ESPERA;
            end
         endcase
      end
   end

   assign ocupado    = ocupado_q;
   assign pronto     = pronto_q;
   assign resultado  = resultado_q;
   assign transbordo = transbordo_q;
   assign estado_dbg = estado_q;

endmodule
